attack_ctl: RTL and testbench
=============================

Name: attack_ctl

Overview:
- Sequences the two-slot attack-rectangle overlay.
- Accepts fire requests from two players and schedules each attack through active and cooldown phases, counted in frames.
- Arbitrates the single shared orientation bit between the two slots.
- Drives the packed x_pos/y_pos/direction inputs of the attack-rectangle draw stage. Updates occur only at frame boundaries, so a drawn frame never tears.

Parameters:
- ACTIVE_FRAMES, 15: frames an attack stays visible (1..255).
- COOLDOWN_FRAMES, 30: frames after an attack before the slot accepts a new fire (1..255).
- SPRITE_W, 40: player sprite width in pixels.
- SPRITE_H, 40: player sprite height in pixels.
- ATT_LEN, 40: attack rectangle long side.
- ATT_OFF, 10: centring offset of the attack across the sprite.
- PARK, 12'hFFF: off-screen coordinate for an idle slot; never matches an 11-bit counter.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- vsync_in  in  1  timing vsync, used for frame tick
- fire  in  2  fire pulse per player; bit0 = player0 = slot0, bit1 = player1 = slot1
- facing0  in  2  player0 facing: 00 right, 01 left, 10 up, 11 down
- facing1  in  2  player1 facing, same encoding
- xpos0, ypos0  in  12 each  player0 sprite top-left
- xpos1, ypos1  in  12 each  player1 sprite top-left
- x_pos  out  24  packed x: [11:0] slot0, [23:12] slot1
- y_pos  out  24  packed y, same packing
- direction  out  1  1 = horizontal (40x20), 0 = vertical (20x40)
- attack_active  out  2  slot is in ACTIVE, for collision logic

Behaviour:
- Reset (rst low, async):
  - x_pos = y_pos = {PARK,PARK}; direction = 1; attack_active = 0.
  - Pending bits cleared; both slots IDLE; counters 0; vsync edge register 0.
- Frame tick: one-cycle pulse, the clk after a vsync_in rising edge (vsync registered once, tick = vs & ~vs_q). All state and output changes occur only on tick cycles, except the pending latch.
- Pending latch: fire[i] high while slot i is IDLE and pending[i]=0:
  - sets pending[i] on the next clk;
  - captures facing[i] into pface[i].
  - fire in any other condition is ignored.
- Per-slot FSM (IDLE, ACTIVE, COOLDOWN), evaluated on tick:
  - ACTIVE: counter decrements. When it reaches 1 on a tick, go to COOLDOWN, load COOLDOWN_FRAMES, park the slot (x,y = PARK) and clear attack_active[i].
  - COOLDOWN: counter decrements. When it reaches 1, go to IDLE.
  - IDLE with pending[i]: subject to grant. If granted, go to ACTIVE, load ACTIVE_FRAMES, clear pending[i], set attack_active[i], load position.
- Grant rule:
  - Orientation of a request is horiz = ~pface[1].
  - A request is granted if the other slot is not ACTIVE after this tick's expirations, or its orientation equals the current direction.
  - Both slots pending with different orientations and no ACTIVE slot: slot0 wins; slot1 stays pending.
  - Same orientation: both are granted on the same tick.
  - On any grant with no slot remaining ACTIVE, direction <= the request's orientation. Otherwise direction holds.
- Position on grant: player position is sampled on the tick cycle; 12-bit unsigned arithmetic.
  - right: x = px+SPRITE_W, y = py+ATT_OFF
  - left: x = px-ATT_LEN, y = py+ATT_OFF
  - up: x = px+ATT_OFF, y = py-ATT_LEN
  - down: x = px+ATT_OFF, y = py+SPRITE_H
  - Subtractions that would go negative clamp to 0.
  - Additions whose true (13-bit) sum exceeds 12'hFFE clamp to 12'hFFE, so PARK is reserved.
- Latency: the fire-to-output delay is the remainder of the current frame, and the output changes on the clk after the grant tick. Visible duration is exactly ACTIVE_FRAMES ticks. A re-fire is accepted no earlier than ACTIVE_FRAMES + COOLDOWN_FRAMES ticks after the grant.
- Player movement while a slot is ACTIVE does not move the attack; the position is frozen at grant.
- Reset mid-operation parks both slots immediately and discards pending requests.

Test Plan:
- Reset asserted -> x_pos = y_pos = 24'hFFF_FFF, direction = 1, attack_active = 00. Then release, with no fire and 5 vsync pulses -> outputs unchanged.
- P0 at (100,200) facing right, fire pulse mid-frame:
  - at next tick: x_pos[11:0] = 140, y_pos[11:0] = 210, direction = 1, attack_active = 01;
  - after 15 ticks: slot0 parked (12'hFFF);
  - fire during the following 30 ticks ignored; fire after that is granted.
- P0 facing left at x = 20 -> x_pos[11:0] = 0 (clamped). P1 facing up at y = 10 -> y_pos[23:12] = 0.
- Same tick, P0 right and P1 up -> slot0 granted, direction = 1, slot1 stays pending. On the tick slot0 expires, slot1 is granted with direction = 0, x_pos[23:12] = px1+10, y_pos[23:12] = py1-40.
- Same tick, P0 left and P1 right -> both granted the same tick, attack_active = 11, direction = 1.
- rst low during ACTIVE on slot1 -> outputs parked asynchronously; after release, no attack resumes without a new fire.

Source files
------------

// File: rtl/attack_ctl.sv
// -----------------------------------------------------------------------------
// attack_ctl
//
// Sequences the two-slot attack-rectangle overlay. Each player's fire request
// is latched as pending. On the next frame tick the slot is scheduled through
// ACTIVE (visible) and COOLDOWN phases, both counted in frames. The single
// shared orientation bit is arbitrated between the slots. The packed
// coordinates for the draw stage change only on frame ticks, so a frame that
// is being drawn never tears.
//
// Ports:
//   clk            pixel clock
//   rst            asynchronous, active-low reset
//   vsync_in       timing vsync; its rising edge produces the frame tick
//   fire[1:0]      fire pulse per player (bit i = player i = slot i)
//   facing0/1      player facing: 00 right, 01 left, 10 up, 11 down
//   xpos0/ypos0    player0 sprite top-left
//   xpos1/ypos1    player1 sprite top-left
//   x_pos[23:0]    packed x: [11:0] slot0, [23:12] slot1 (PARK when idle)
//   y_pos[23:0]    packed y, same packing
//   direction      1 = horizontal (40x20), 0 = vertical (20x40)
//   attack_active  slot i is in ACTIVE, for collision logic
// -----------------------------------------------------------------------------
module attack_ctl #(
   parameter int ACTIVE_FRAMES   = 15,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int SPRITE_W        = 40,
   parameter int SPRITE_H        = 40,
   parameter int ATT_LEN         = 40,
   parameter int ATT_OFF         = 10,
   parameter logic [11:0] PARK   = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic [1:0]  fire,
   input  logic [1:0]  facing0,
   input  logic [1:0]  facing1,
   input  logic [11:0] xpos0,
   input  logic [11:0] ypos0,
   input  logic [11:0] xpos1,
   input  logic [11:0] ypos1,
   output logic [23:0] x_pos,
   output logic [23:0] y_pos,
   output logic        direction,
   output logic [1:0]  attack_active
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_COOLDOWN = 2'd2
   } slot_state_t;

   localparam logic [11:0] SPRITE_W12 = 12'(SPRITE_W);
   localparam logic [11:0] SPRITE_H12 = 12'(SPRITE_H);
   localparam logic [11:0] ATT_LEN12  = 12'(ATT_LEN);
   localparam logic [11:0] ATT_OFF12  = 12'(ATT_OFF);
   localparam logic [7:0]  ACT_CNT    = 8'(ACTIVE_FRAMES);
   localparam logic [7:0]  COOL_CNT   = 8'(COOLDOWN_FRAMES);

   // Additions saturate one below PARK so that a live attack can never look
   // like an idle slot.
   function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
      logic [12:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > 13'hFFE) ? 12'hFFE : s[11:0];
   endfunction

   function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
      return (a < b) ? 12'd0 : (a - b);
   endfunction

   // State
   slot_state_t state_reg [2];
   logic [7:0]  cnt_reg   [2];
   logic [1:0]  pface_reg [2];
   logic [11:0] x_reg     [2];
   logic [11:0] y_reg     [2];
   logic [1:0]  pending_reg;
   logic [1:0]  active_reg;
   logic        dir_reg;
   logic        vs_q_reg;

   // Per-slot views of the player inputs
   logic [1:0]  facing_w [2];
   logic [11:0] px_w     [2];
   logic [11:0] py_w     [2];
   logic [11:0] att_x_w  [2];
   logic [11:0] att_y_w  [2];

   logic [1:0]  horiz_w;    // orientation of the pending request
   logic [1:0]  remain_w;   // slot still ACTIVE after this tick's expiration
   logic [1:0]  req_w;      // slot is asking for a grant on this tick
   logic [1:0]  ok_w;       // request compatible with the surviving ACTIVE slot
   logic [1:0]  grant_w;
   logic        tick;
   logic        new_dir;

   assign tick = vsync_in & ~vs_q_reg;

   assign facing_w[0] = facing0;
   assign facing_w[1] = facing1;
   assign px_w[0]     = xpos0;
   assign px_w[1]     = xpos1;
   assign py_w[0]     = ypos0;
   assign py_w[1]     = ypos1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         assign horiz_w[gi]  = ~pface_reg[gi][1];
         assign remain_w[gi] = (state_reg[gi] == ST_ACTIVE) && (cnt_reg[gi] != 8'd1);
         assign req_w[gi]    = tick && (state_reg[gi] == ST_IDLE) && pending_reg[gi];
         // The other slot only constrains us if it keeps being drawn past
         // this tick; then we must share its orientation.
         assign ok_w[gi]     = req_w[gi] &&
                               (!remain_w[1-gi] || (horiz_w[gi] == dir_reg));

         always_comb begin
            att_x_w[gi] = PARK;
            att_y_w[gi] = PARK;
            case (pface_reg[gi])
               2'b00: begin
                  att_x_w[gi] = sat_add(px_w[gi], SPRITE_W12);
                  att_y_w[gi] = sat_add(py_w[gi], ATT_OFF12);
               end
               2'b01: begin
                  att_x_w[gi] = sat_sub(px_w[gi], ATT_LEN12);
                  att_y_w[gi] = sat_add(py_w[gi], ATT_OFF12);
               end
               2'b10: begin
                  att_x_w[gi] = sat_add(px_w[gi], ATT_OFF12);
                  att_y_w[gi] = sat_sub(py_w[gi], ATT_LEN12);
               end
               default: begin
                  att_x_w[gi] = sat_add(px_w[gi], ATT_OFF12);
                  att_y_w[gi] = sat_add(py_w[gi], SPRITE_H12);
               end
            endcase
         end

         assign x_pos[12*gi +: 12] = x_reg[gi];
         assign y_pos[12*gi +: 12] = y_reg[gi];
      end
   endgenerate

   // Slot0 has priority: slot1 is held back when both are granted together
   // with conflicting orientations.
   assign grant_w[0] = ok_w[0];
   assign grant_w[1] = ok_w[1] && !(ok_w[0] && (horiz_w[0] != horiz_w[1]));
   assign new_dir    = grant_w[0] ? horiz_w[0] : horiz_w[1];

   assign direction     = dir_reg;
   assign attack_active = active_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_q_reg    <= 1'b0;
         pending_reg <= 2'b00;
         active_reg  <= 2'b00;
         dir_reg     <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            state_reg[i] <= ST_IDLE;
            cnt_reg[i]   <= 8'd0;
            pface_reg[i] <= 2'b00;
            x_reg[i]     <= PARK;
            y_reg[i]     <= PARK;
         end
      end else begin
         vs_q_reg <= vsync_in;

         for (int i = 0; i < 2; i++) begin
            // Pending latch runs every clock; it never coincides with a grant
            // because a grant needs pending already set.
            if (fire[i] && (state_reg[i] == ST_IDLE) && !pending_reg[i]) begin
               pending_reg[i] <= 1'b1;
               pface_reg[i]   <= facing_w[i];
            end

            if (tick) begin
               case (state_reg[i])
                  ST_ACTIVE: begin
                     if (cnt_reg[i] == 8'd1) begin
                        state_reg[i]  <= ST_COOLDOWN;
                        cnt_reg[i]    <= COOL_CNT;
                        x_reg[i]      <= PARK;
                        y_reg[i]      <= PARK;
                        active_reg[i] <= 1'b0;
                     end else begin
                        cnt_reg[i] <= cnt_reg[i] - 8'd1;
                     end
                  end
                  ST_COOLDOWN: begin
                     if (cnt_reg[i] == 8'd1) begin
                        state_reg[i] <= ST_IDLE;
                        cnt_reg[i]   <= 8'd0;
                     end else begin
                        cnt_reg[i] <= cnt_reg[i] - 8'd1;
                     end
                  end
                  default: begin
                     if (grant_w[i]) begin
                        state_reg[i]   <= ST_ACTIVE;
                        cnt_reg[i]     <= ACT_CNT;
                        pending_reg[i] <= 1'b0;
                        active_reg[i]  <= 1'b1;
                        x_reg[i]       <= att_x_w[i];
                        y_reg[i]       <= att_y_w[i];
                     end
                  end
               endcase
            end
         end

         // Orientation may only switch when nothing stays on screen.
         if (tick && (|grant_w) && !(|remain_w)) begin
            dir_reg <= new_dir;
         end
      end
   end

endmodule

// File: tb/tb_attack_ctl.sv
module tb_attack_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vsync_in = 1'b0;
   logic [1:0]  fire = 2'b00;
   logic [1:0]  facing0 = 2'b00;
   logic [1:0]  facing1 = 2'b00;
   logic [11:0] xpos0 = 12'd0;
   logic [11:0] ypos0 = 12'd0;
   logic [11:0] xpos1 = 12'd0;
   logic [11:0] ypos1 = 12'd0;
   logic [23:0] x_pos;
   logic [23:0] y_pos;
   logic        direction;
   logic [1:0]  attack_active;

   int checks = 0;
   int errs   = 0;

   attack_ctl dut (
      .clk           (clk),
      .rst           (rst),
      .vsync_in      (vsync_in),
      .fire          (fire),
      .facing0       (facing0),
      .facing1       (facing1),
      .xpos0         (xpos0),
      .ypos0         (ypos0),
      .xpos1         (xpos1),
      .ypos1         (ypos1),
      .x_pos         (x_pos),
      .y_pos         (y_pos),
      .direction     (direction),
      .attack_active (attack_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  fire;
      logic [1:0]  f0;
      logic [1:0]  f1;
      logic [11:0] x0;
      logic [11:0] y0;
      logic [11:0] x1;
      logic [11:0] y1;
      logic [23:0] ex;
      logic [23:0] ey;
      logic        ed;
      logic [1:0]  ea;
   } vec_t;

   vec_t vecs [10];

   localparam logic [11:0] P = 12'hFFF;

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   // One frame: vsync high for one clock, tick happens at the next edge.
   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk) vsync_in = 1'b1;
         @(negedge clk) vsync_in = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic pulse_fire(input logic [1:0] f);
      @(negedge clk) fire = f;
      @(negedge clk) fire = 2'b00;
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_all(input string nm, input logic [23:0] ex, input logic [23:0] ey,
                          input logic ed, input logic [1:0] ea);
      chk({nm, ".x"},   x_pos, ex);
      chk({nm, ".y"},   y_pos, ey);
      chk({nm, ".dir"}, {23'd0, direction}, {23'd0, ed});
      chk({nm, ".act"}, {22'd0, attack_active}, {22'd0, ea});
   endtask

   initial begin
      // facing: 00 right, 01 left, 10 up, 11 down
      vecs[0] = '{"p0_right",       2'b01, 2'b00, 2'b00, 12'd100,  12'd200,  12'd0,    12'd0,
                  {P, 12'd140},       {P, 12'd210},       1'b1, 2'b01};
      vecs[1] = '{"p0_left_clamp",  2'b01, 2'b01, 2'b00, 12'd20,   12'd50,   12'd0,    12'd0,
                  {P, 12'd0},         {P, 12'd60},        1'b1, 2'b01};
      vecs[2] = '{"p1_up_clamp",    2'b10, 2'b00, 2'b10, 12'd0,    12'd0,    12'd300,  12'd10,
                  {12'd310, P},       {12'd0, P},         1'b0, 2'b10};
      vecs[3] = '{"prio_slot0",     2'b11, 2'b00, 2'b10, 12'd100,  12'd200,  12'd300,  12'd500,
                  {P, 12'd140},       {P, 12'd210},       1'b1, 2'b01};
      vecs[4] = '{"both_horiz",     2'b11, 2'b01, 2'b00, 12'd100,  12'd200,  12'd300,  12'd500,
                  {12'd340, 12'd60},  {12'd510, 12'd210}, 1'b1, 2'b11};
      vecs[5] = '{"p0_down",        2'b01, 2'b11, 2'b00, 12'd100,  12'd200,  12'd0,    12'd0,
                  {P, 12'd110},       {P, 12'd240},       1'b0, 2'b01};
      vecs[6] = '{"p1_right_sat",   2'b10, 2'b00, 2'b00, 12'd0,    12'd0,    12'd4090, 12'd0,
                  {12'hFFE, P},       {12'd10, P},        1'b1, 2'b10};
      vecs[7] = '{"p0_down_sat",    2'b01, 2'b11, 2'b00, 12'd4090, 12'd4060, 12'd0,    12'd0,
                  {P, 12'hFFE},       {P, 12'hFFE},       1'b0, 2'b01};
      vecs[8] = '{"p0_up_exact0",   2'b01, 2'b10, 2'b00, 12'd100,  12'd40,   12'd0,    12'd0,
                  {P, 12'd110},       {P, 12'd0},         1'b0, 2'b01};
      vecs[9] = '{"p1_left_exact0", 2'b10, 2'b00, 2'b01, 12'd0,    12'd0,    12'd40,   12'd500,
                  {12'd0, P},         {12'd510, P},       1'b1, 2'b10};

      // Reset state, then idle frames leave it untouched
      repeat (2) @(negedge clk);
      chk_all("reset", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'b00);
      rst = 1'b1;
      frames(5);
      chk_all("idle5", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'b00);

      // Table: one fire pulse, one frame, compare
      for (int v = 0; v < 10; v++) begin
         do_reset();
         facing0 = vecs[v].f0; facing1 = vecs[v].f1;
         xpos0 = vecs[v].x0;   ypos0 = vecs[v].y0;
         xpos1 = vecs[v].x1;   ypos1 = vecs[v].y1;
         pulse_fire(vecs[v].fire);
         frames(1);
         chk_all(vecs[v].name, vecs[v].ex, vecs[v].ey, vecs[v].ed, vecs[v].ea);
      end

      // Duration, frozen position, cooldown boundary
      do_reset();
      facing0 = 2'b00; xpos0 = 12'd100; ypos0 = 12'd200;
      pulse_fire(2'b01);
      repeat (4) @(negedge clk);
      chk("pre_tick.act", {22'd0, attack_active}, 24'd0);
      frames(1);                       // tick 0: grant
      xpos0 = 12'd700; ypos0 = 12'd700;
      frames(14);                      // ticks 1..14
      chk_all("frozen14", {P, 12'd140}, {P, 12'd210}, 1'b1, 2'b01);
      frames(1);                       // tick 15: expire
      chk_all("expired", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'b00);
      pulse_fire(2'b01);
      frames(1);                       // tick 16
      chk("cool_fire.act", {22'd0, attack_active}, 24'd0);
      frames(28);                      // ticks 17..44
      pulse_fire(2'b01);               // still in cooldown: ignored
      frames(1);                       // tick 45: back to idle
      chk("cool_last.act", {22'd0, attack_active}, 24'd0);
      xpos0 = 12'd100; ypos0 = 12'd200;
      pulse_fire(2'b01);
      frames(1);                       // tick 46: granted
      chk("refire.act", {22'd0, attack_active}, 24'd1);
      chk("refire.x", x_pos, {P, 12'd140});

      // Slot1 waits for slot0 to expire, then takes the vertical direction
      do_reset();
      facing0 = 2'b00; xpos0 = 12'd100; ypos0 = 12'd200;
      facing1 = 2'b10; xpos1 = 12'd300; ypos1 = 12'd500;
      pulse_fire(2'b11);
      frames(1);
      chk_all("arb_t0", {P, 12'd140}, {P, 12'd210}, 1'b1, 2'b01);
      frames(14);
      chk("arb_t14.act", {22'd0, attack_active}, 24'd1);
      frames(1);
      chk_all("arb_t15", {12'd310, P}, {12'd460, P}, 1'b0, 2'b10);

      // Asynchronous reset while slot1 is active
      do_reset();
      facing1 = 2'b00; xpos1 = 12'd300; ypos1 = 12'd500;
      pulse_fire(2'b10);
      frames(1);
      chk("pre_rst.act", {22'd0, attack_active}, 24'd2);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk_all("async_rst", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'b00);
      @(negedge clk) rst = 1'b1;
      frames(3);
      chk_all("post_rst", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end

endmodule
